// File: rtl/efuse_readback.sv
// eFuse serial readback: captures Q on SCLK rising edges into a parallel word.
// Optional readback compare against prog enabled by EFUSE_READBACK_COMPARE_EN.
module efuse_readback #(
    parameter int NBITS = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             CSB,
    input  logic             PGM,
    input  logic             SCLK,
    input  logic             Q,
    input  logic [NBITS-1:0] prog,
    output logic [NBITS-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             ovf_err,
    output logic             mismatch
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] NB = CNTW'(NBITS);

    state_t           state_q;
    logic             csb_q;
    logic             sclk_q;
    logic [NBITS-1:0] shreg_q;
    logic [CNTW-1:0]  cnt_q;
    logic             ovf_seen_q;
    logic [NBITS-1:0] data_out_q;
    logic             data_valid_q;
    logic             busy_q;
    logic             frame_err_q;
    logic             ovf_err_q;

    logic csb_fall;
    logic csb_rise;
    logic sclk_rise;
    logic rd_ok;
    logic cnt_full;

    assign csb_fall  = csb_q & ~CSB;
    assign csb_rise  = ~csb_q & CSB;
    assign sclk_rise = ~sclk_q & SCLK;
    assign rd_ok     = (mode == 2'b10) && !PGM;
    assign cnt_full  = (cnt_q == NB);

`ifdef EFUSE_READBACK_COMPARE_EN
    logic mismatch_q;
    assign mismatch = mismatch_q;
`else
    logic unused_prog;
    assign unused_prog = ^prog;
    assign mismatch    = 1'b0;
`endif

    // Capture FSM: edge detection, shifting, framing checks and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            csb_q        <= 1'b1;
            sclk_q       <= 1'b0;
            shreg_q      <= '0;
            cnt_q        <= '0;
            ovf_seen_q   <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            ovf_err_q    <= 1'b0;
`ifdef EFUSE_READBACK_COMPARE_EN
            mismatch_q   <= 1'b0;
`endif
        end else begin
            csb_q        <= CSB;
            sclk_q       <= SCLK;
            data_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (csb_fall && rd_ok) begin
                        state_q    <= S_SHIFT;
                        shreg_q    <= '0;
                        cnt_q      <= '0;
                        ovf_seen_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (!rd_ok) begin
                        // abort: controller left read mode mid-frame
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        frame_err_q <= 1'b1;
`ifdef EFUSE_READBACK_COMPARE_EN
                        mismatch_q  <= 1'b1;
`endif
                    end else if (csb_rise) begin
                        busy_q <= 1'b0;
                        if (cnt_full) begin
                            state_q     <= S_DONE;
                            frame_err_q <= 1'b0;
                            ovf_err_q   <= ovf_seen_q;
                        end else begin
                            state_q     <= S_IDLE;
                            frame_err_q <= 1'b1;
`ifdef EFUSE_READBACK_COMPARE_EN
                            mismatch_q  <= 1'b1;
`endif
                        end
                    end else if (sclk_rise) begin
                        if (!cnt_full) begin
                            shreg_q <= shreg_q | (NBITS'(Q) << cnt_q);
                            cnt_q   <= cnt_q + CNTW'(1);
                        end else begin
                            ovf_err_q  <= 1'b1;
                            ovf_seen_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q      <= S_IDLE;
                    data_out_q   <= shreg_q;
                    data_valid_q <= 1'b1;
`ifdef EFUSE_READBACK_COMPARE_EN
                    mismatch_q   <= (shreg_q != prog);
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign ovf_err    = ovf_err_q;

endmodule

// File: doc/efuse_readback.md
Name: efuse_readback

Overview:
- Consumes the serial strobes (CSB, PGM, SCLK) generated by the eFuse control state machine in read mode.
- Captures the eFuse serial output Q into a parallel 32-bit word.
- Reports word completion, framing errors and overflow to the slow-control register file.
- Runs in the same divided clock domain that generates SCLK, so every strobe is synchronous and is sampled directly. No synchronizers.

Parameters:
- NBITS, 32: number of fuse bits per read frame. Range 2..64.
- CNTW, 6: bit-counter width. Must satisfy 2**CNTW > NBITS.

Ports:
- clk  input  1  divided eFuse clock, same domain as the controller that drives SCLK
- rst  input  1  synchronous reset, active-high
- mode  input  2  2'b10 = read mode; any other value blocks or aborts a capture
- CSB  input  1  eFuse chip select from the controller, active-low
- PGM  input  1  eFuse program strobe from the controller; must be 0 during a read
- SCLK  input  1  eFuse serial clock from the controller
- Q  input  1  eFuse serial data output
- prog  input  NBITS  expected fuse pattern; used only with the optional feature
- data_out  output  NBITS  last complete read word
- data_valid  output  1  one-cycle pulse when data_out updates
- busy  output  1  high while a frame is being captured
- frame_err  output  1  sticky: frame ended or aborted with fewer than NBITS bits
- ovf_err  output  1  sticky: more than NBITS SCLK rising edges in one frame
- mismatch  output  1  optional-feature output: readback differs from prog

Behaviour:
- Internal registers:
  - csb_d, sclk_d: previous-cycle copies of CSB and SCLK.
  - csb_fall = csb_d & ~CSB; csb_rise = ~csb_d & CSB; sclk_rise = ~sclk_d & SCLK.
- Reset (rst=1 at a clk edge):
  - state=IDLE, shift register=0, counter=0.
  - data_out=0, data_valid=0, busy=0, frame_err=0, ovf_err=0, mismatch=0.
  - csb_d=1, sclk_d=0.
- IDLE:
  - Goes to SHIFT on csb_fall when mode==2'b10 and PGM==0.
  - Entering SHIFT clears the shift register and sets counter=0.
  - Any other csb_fall is ignored.
- SHIFT:
  - busy=1.
  - On sclk_rise with counter<NBITS: shreg[counter]<=Q (LSB-first, first bit goes to bit 0); counter+1.
  - On sclk_rise with counter==NBITS: data is ignored and ovf_err<=1.
  - On csb_rise:
    - counter==NBITS: go to DONE.
    - Otherwise: frame_err<=1, go to IDLE, data_out unchanged.
  - Abort: mode!=2'b10 or PGM==1 while in SHIFT → frame_err<=1, go to IDLE.
  - Priority when events coincide: abort > csb_rise > sclk_rise. An edge coinciding with csb_rise is not captured.
- DONE (one cycle):
  - data_out<=shreg; data_valid=1 for exactly this cycle; busy=0; then IDLE.
  - Latency: data_valid is high in the 2nd clk cycle after the cycle in which CSB is first sampled high.
- Sticky flags:
  - frame_err and ovf_err clear only on rst or on the next successful DONE entry.
  - On that DONE entry, ovf_err is instead set if overflow occurred in the current frame.
- csb_fall while in SHIFT or DONE is ignored.
- A new frame may start on the cycle after DONE.
- Back-to-back frames need no idle gap beyond the DONE cycle.

Optional Feature:
- Macro: EFUSE_READBACK_COMPARE_EN.
- Defined:
  - In DONE, mismatch<=(shreg!=prog); it holds until the next DONE or rst.
  - It is also forced to 1 on a frame_err event.
- Undefined:
  - mismatch is tied to 0.
  - The prog port remains present but unused.
  - No compare logic is synthesized.

Test Plan:
- Read frame, mode=2'b10, 32 SCLK pulses carrying 32'hA5A5_1234 LSB-first, then CSB high → data_out=32'hA5A51234, one data_valid pulse 2 cycles after CSB high, frame_err=0, ovf_err=0.
- Short frame, only 16 SCLK pulses (data 16'hBEEF) then CSB high → frame_err=1, data_valid never asserts, data_out keeps the prior 32'hA5A51234.
- Over-length frame, 33 pulses (first 32 carry 32'h0000_00FF, 33rd Q=1) → data_out=32'h000000FF, data_valid pulses, ovf_err=1.
- Program-mode isolation: mode=2'b01, PGM pulses, CSB low, 32 SCLK pulses → state stays IDLE, busy=0, no data_valid. Then mode changed to 2'b00 mid-read → frame_err=1.
- Reset mid-frame: rst=1 after 10 bits → all outputs 0 next cycle. A following full frame of 32'hFFFF_FFFF → data_out=32'hFFFFFFFF.
- With EFUSE_READBACK_COMPARE_EN, prog=32'h1234_5678:
  - Readback 32'h12345678 → mismatch=0.
  - Readback 32'h12345679 → mismatch=1.
  - Without the macro → mismatch stays 0.
